cc_life_counter: RTL and testbench
==================================

# cc_life_counter

Holds the frog's remaining-lives count for the Frogger datapath and is the producer side of the life bus that the lives-exhausted comparator reads. Decrements on collision strobes, increments on bonus strobes with saturation, and applies a post-hit grace (invulnerability) window so a single collision spanning several frames costs exactly one life. Sits between the collision/bonus detection logic and the life comparator / score display.

## Interface
- LIFECOUNTER_DATAWIDTH, 8, width of the life bus.
- LIFECOUNTER_INIT_LIVES, 3, value loaded on reset and on start.
- LIFECOUNTER_MAX_LIVES, 9, saturation ceiling for bonuses; must be ≤ 2^DATAWIDTH−1 and ≥ INIT_LIVES.
- LIFECOUNTER_GRACE_CYCLES, 64, length of the invulnerability window in clock cycles; ≥ 1.

- CC_LIFE_COUNTER_CLOCK_50  in  1  system clock; the block's only clock.
- CC_LIFE_COUNTER_RESET_InHigh  in  1  reset, synchronous, active-high.
- CC_LIFE_COUNTER_start_InLow  in  1  one-cycle active-low strobe: new game.
- CC_LIFE_COUNTER_hit_InLow  in  1  one-cycle active-low strobe: collision detected.
- CC_LIFE_COUNTER_bonus_InLow  in  1  one-cycle active-low strobe: extra life earned.
- CC_LIFE_COUNTER_data_OutBUS  out  DATAWIDTH  current life count, drives the comparator.
- CC_LIFE_COUNTER_grace_OutHigh  out  1  high while the grace window is active.
- CC_LIFE_COUNTER_gameover_OutLow  out  1  low while in DEAD.
- CC_LIFE_COUNTER_hitack_OutHigh  out  1  one-cycle pulse when a hit is accepted (count decremented).

## Operation
- States: IDLE, PLAY, GRACE, DEAD. All outputs registered, decoded from state/registers.
- Reset values: state IDLE, count = INIT_LIVES, grace timer 0, grace_OutHigh 0, gameover_OutLow 1, hitack_OutHigh 0.
- Priority in every state: reset > start > hit > bonus.
- start (any state): count ← INIT_LIVES, timer ← 0, state ← PLAY. Hit/bonus sampled the same cycle are discarded.
- IDLE: hit and bonus ignored; count held.
- PLAY, hit only: count ← count−1, hitack pulses. If new count = 0 → DEAD; else → GRACE, timer ← GRACE_CYCLES−1.
- PLAY, hit and bonus same cycle: net count unchanged, hitack pulses, → GRACE (count ≥ 1 before, so never DEAD).
- PLAY, bonus only: count ← min(count+1, MAX_LIVES).
- GRACE: hit ignored (no hitack). Bonus applied as in PLAY. Timer decrements each cycle; in the cycle timer = 0 the state → PLAY.
- DEAD: count held at 0; hit and bonus ignored; only start or reset leaves.
- Count never underflows below 0 and never exceeds MAX_LIVES; unsigned arithmetic at DATAWIDTH bits.

## Timing
- Strobes sampled on rising edge; count, state and flags update on that same edge (outputs valid one cycle after the strobe is presented).
- hitack_OutHigh high for exactly the cycle following the accepting edge.
- grace_OutHigh high for exactly GRACE_CYCLES cycles after an accepted non-fatal hit; a hit presented on the first PLAY cycle after GRACE is accepted.
- gameover_OutLow falls in the same cycle the count becomes 0.
- Reset asserted mid-GRACE or mid-DEAD returns to IDLE on the next edge, timer cleared.
- Held-low strobes are not edge-detected here: each low cycle in PLAY is a separate event (upstream guarantees single-cycle pulses).

## Structure
- Shared package: state encoding localparams (IDLE/PLAY/GRACE/DEAD), default lives/ceiling constants for the game.
- Grace timer width = $clog2(GRACE_CYCLES+1).
- One sub-module: cc_grace_timer (loadable down-counter with load, enable, zero flag); FSM and count register stay in cc_life_counter.

## Test plan
- Reset then idle: data_OutBUS = 3, gameover_OutLow = 1, grace 0; hit/bonus in IDLE leave count at 3.
- start, hit: count 3→2, hitack 1 cycle, grace high 64 cycles; second hit at cycle +10 ignored, count stays 2.
- Three hits each spaced ≥ 65 cycles after start: count 2,1,0; third hit gives gameover_OutLow = 0, grace stays 0; later bonus ignored, count 0.
- Bonus saturation: start, 7 bonuses → count 9 after 6th, stays 9 after 7th.
- Simultaneous hit+bonus in PLAY with count 1: count stays 1, hitack pulses, state GRACE, no gameover.
- start during GRACE with count 1: count 3, grace drops next cycle; reset asserted in DEAD returns count 3, gameover_OutLow 1.

Source files
------------

// File: rtl/cc_life_counter_pkg.sv
// Shared definitions for the Frogger life counter: state encoding and the
// default game constants for lives and the post-hit grace window.
package cc_life_counter_pkg;

  // State encoding, kept as plain constants so checkers can compare
  // against the debug state port without pulling in the enum type.
  localparam logic [1:0] LC_ST_IDLE  = 2'd0;
  localparam logic [1:0] LC_ST_PLAY  = 2'd1;
  localparam logic [1:0] LC_ST_GRACE = 2'd2;
  localparam logic [1:0] LC_ST_DEAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LC_ST_IDLE,
    ST_PLAY  = LC_ST_PLAY,
    ST_GRACE = LC_ST_GRACE,
    ST_DEAD  = LC_ST_DEAD
  } lc_state_t;

  // Default game constants
  localparam int LC_DATAWIDTH     = 8;
  localparam int LC_INIT_LIVES    = 3;
  localparam int LC_MAX_LIVES     = 9;
  localparam int LC_GRACE_CYCLES  = 64;

endpackage

// File: rtl/cc_grace_timer.sv
// Loadable down-counter for the invulnerability window. Load puts it at
// GRACE_CYCLES-1 so that, counting down to and including zero, the window
// lasts exactly GRACE_CYCLES cycles. zero_o flags the last window cycle.
module cc_grace_timer
  import cc_life_counter_pkg::*;
#(
  parameter int GRACE_CYCLES = LC_GRACE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int TW = $clog2(GRACE_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(GRACE_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next timer value: clear beats load beats countdown; stops at zero.
  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (load_i) begin
      timer_d = LOAD_VAL;
    end else if (en_i && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign zero_o = (timer_q == '0);

endmodule

// File: rtl/cc_life_counter.sv
// Remaining-lives counter for the Frogger datapath. Collision strobes cost
// one life and open a grace window during which further hits are ignored;
// bonus strobes add a life up to a ceiling. All outputs are registered.
//
// Strobe semantics: start/hit/bonus are single-cycle active-low pulses
// sampled on the rising edge; there is no backpressure. Each low cycle is a
// distinct event, and results appear on the outputs one cycle later.
module cc_life_counter
  import cc_life_counter_pkg::*;
#(
  parameter int LIFECOUNTER_DATAWIDTH    = LC_DATAWIDTH,
  parameter int LIFECOUNTER_INIT_LIVES   = LC_INIT_LIVES,
  parameter int LIFECOUNTER_MAX_LIVES    = LC_MAX_LIVES,
  parameter int LIFECOUNTER_GRACE_CYCLES = LC_GRACE_CYCLES
) (
  input  logic                             CC_LIFE_COUNTER_CLOCK_50,
  input  logic                             CC_LIFE_COUNTER_RESET_InHigh,
  input  logic                             CC_LIFE_COUNTER_start_InLow,
  input  logic                             CC_LIFE_COUNTER_hit_InLow,
  input  logic                             CC_LIFE_COUNTER_bonus_InLow,
  output logic [LIFECOUNTER_DATAWIDTH-1:0] CC_LIFE_COUNTER_data_OutBUS,
  output logic                             CC_LIFE_COUNTER_grace_OutHigh,
  output logic                             CC_LIFE_COUNTER_gameover_OutLow,
  output logic                             CC_LIFE_COUNTER_hitack_OutHigh,
  output logic [1:0]                       dbg_state_o
);

  localparam int DW = LIFECOUNTER_DATAWIDTH;
  localparam logic [DW-1:0] INIT_LV = DW'(LIFECOUNTER_INIT_LIVES);
  localparam logic [DW-1:0] MAX_LV  = DW'(LIFECOUNTER_MAX_LIVES);

  lc_state_t     state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic          hitack_q, grace_q, gameover_n_q;
  logic          hit_acc;
  logic          tmr_load;
  logic          tmr_zero;

  logic          start_s, hit_s, bonus_s;
  logic [DW-1:0] count_inc, count_dec;

  assign start_s = ~CC_LIFE_COUNTER_start_InLow;
  assign hit_s   = ~CC_LIFE_COUNTER_hit_InLow;
  assign bonus_s = ~CC_LIFE_COUNTER_bonus_InLow;

  // Saturating increment and floor-at-zero decrement.
  assign count_inc = (count_q >= MAX_LV) ? MAX_LV : count_q + DW'(1);
  assign count_dec = (count_q == '0) ? '0 : count_q - DW'(1);

  cc_grace_timer #(
    .GRACE_CYCLES (LIFECOUNTER_GRACE_CYCLES)
  ) u_grace_timer (
    .clk_i  (CC_LIFE_COUNTER_CLOCK_50),
    .rst_i  (CC_LIFE_COUNTER_RESET_InHigh),
    .clr_i  (start_s),
    .load_i (tmr_load),
    .en_i   (state_q == ST_GRACE),
    .zero_o (tmr_zero)
  );

  // Next state / count: start overrides everything, then hit, then bonus.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hit_acc  = 1'b0;
    tmr_load = 1'b0;
    if (start_s) begin
      state_d = ST_PLAY;
      count_d = INIT_LV;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (hit_s) begin
            hit_acc = 1'b1;
            if (bonus_s) begin
              // Hit and bonus cancel; the hit still opens a grace window.
              state_d  = ST_GRACE;
              tmr_load = 1'b1;
            end else begin
              count_d = count_dec;
              if (count_dec == '0) begin
                state_d = ST_DEAD;
              end else begin
                state_d  = ST_GRACE;
                tmr_load = 1'b1;
              end
            end
          end else if (bonus_s) begin
            count_d = count_inc;
          end
        end
        ST_GRACE: begin
          if (bonus_s) begin
            count_d = count_inc;
          end
          if (tmr_zero) begin
            state_d = ST_PLAY;
          end
        end
        ST_DEAD: begin
          count_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // FSM, count and registered output flags.
  always_ff @(posedge CC_LIFE_COUNTER_CLOCK_50) begin
    if (CC_LIFE_COUNTER_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      count_q      <= INIT_LV;
      hitack_q     <= 1'b0;
      grace_q      <= 1'b0;
      gameover_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hitack_q     <= hit_acc;
      grace_q      <= (state_d == ST_GRACE);
      gameover_n_q <= (state_d != ST_DEAD);
    end
  end

  assign CC_LIFE_COUNTER_data_OutBUS     = count_q;
  assign CC_LIFE_COUNTER_grace_OutHigh   = grace_q;
  assign CC_LIFE_COUNTER_gameover_OutLow = gameover_n_q;
  assign CC_LIFE_COUNTER_hitack_OutHigh  = hitack_q;
  assign dbg_state_o                     = state_q;

endmodule

// File: tb/tb_cc_life_counter.sv
// Bench for cc_life_counter: directed strobe sequences, expected outputs
// queued by the driver and compared by independent monitors.
module tb_cc_life_counter;

  localparam int W = 12;  // {state[1:0], count[7:0], grace, gameover_n}
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_GRACE = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       hit_n = 1'b1;
  logic       bonus_n = 1'b1;
  logic [7:0] data;
  logic       grace;
  logic       gameover_n;
  logic       hitack;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   ack_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  cc_life_counter dut (
    .CC_LIFE_COUNTER_CLOCK_50        (clk),
    .CC_LIFE_COUNTER_RESET_InHigh    (rst),
    .CC_LIFE_COUNTER_start_InLow     (start_n),
    .CC_LIFE_COUNTER_hit_InLow       (hit_n),
    .CC_LIFE_COUNTER_bonus_InLow     (bonus_n),
    .CC_LIFE_COUNTER_data_OutBUS     (data),
    .CC_LIFE_COUNTER_grace_OutHigh   (grace),
    .CC_LIFE_COUNTER_gameover_OutLow (gameover_n),
    .CC_LIFE_COUNTER_hitack_OutHigh  (hitack),
    .dbg_state_o                     (state_dbg)
  );

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One strobe cycle; returns just after the edge that sampled it.
  task automatic apply(input logic s, input logic h, input logic b);
    @(posedge clk);
    #1;
    start_n = ~s;
    hit_n   = ~h;
    bonus_n = ~b;
    @(posedge clk);
    #1;
    start_n = 1'b1;
    hit_n   = 1'b1;
    bonus_n = 1'b1;
  endtask

  task automatic expect_out(input logic [1:0] st, input logic [7:0] cnt,
                            input logic gr, input logic go_n);
    exp_q.push_back({st, cnt, gr, go_n});
  endtask

  // Scoreboard monitor: output snapshot vs. queued expectation.
  always @(negedge clk) begin : out_mon
    logic [W-1:0] e;
    logic [W-1:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_dbg, data, grace, gameover_n};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got state=%0d count=%0d grace=%0b gameover_n=%0b required state=%0d count=%0d grace=%0b gameover_n=%0b",
                 $time, a[11:10], a[9:2], a[1], a[0], e[11:10], e[9:2], e[1], e[0]);
      end
    end
  end

  // Hit-acknowledge monitor: every pulse must match a queued acceptance.
  always @(negedge clk) begin : ack_mon
    logic [7:0] ec;
    if (!rst && hitack !== 1'b0) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL hitack_unexpected t=%0t got hitack=%b count=%0d required no pulse",
                 $time, hitack, data);
      end else begin
        ec = ack_q.pop_front();
        if (data !== ec) begin
          errors++;
          $display("FAIL hitack_count t=%0t got count=%0d required %0d", $time, data, ec);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin : stim
    logic [7:0] sat;
    // Reset and IDLE behaviour
    wait_cycles(3);
    rst = 1'b0;
    expect_out(S_IDLE, 8'd3, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    expect_out(S_IDLE, 8'd3, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1);
    expect_out(S_IDLE, 8'd3, 1'b0, 1'b1);

    // First hit, grace window length, ignored second hit
    apply(1'b1, 1'b0, 1'b0);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd2);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    wait_cycles(8);
    apply(1'b0, 1'b1, 1'b0);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    wait_cycles(53);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    wait_cycles(1);
    expect_out(S_PLAY, 8'd2, 1'b0, 1'b1);

    // Three hits to game over; second hit lands on first PLAY cycle
    apply(1'b1, 1'b0, 1'b0);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd2);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    wait_cycles(63);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd1);
    expect_out(S_GRACE, 8'd1, 1'b1, 1'b1);
    wait_cycles(64);
    expect_out(S_PLAY, 8'd1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd0);
    expect_out(S_DEAD, 8'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1);
    expect_out(S_DEAD, 8'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    expect_out(S_DEAD, 8'd0, 1'b0, 1'b0);
    do_reset(1);
    expect_out(S_IDLE, 8'd3, 1'b0, 1'b1);

    // Bonus saturation at 9
    apply(1'b1, 1'b0, 1'b0);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      sat = (i + 4 > 9) ? 8'd9 : 8'(i + 4);
      expect_out(S_PLAY, sat, 1'b0, 1'b1);
    end

    // Simultaneous hit and bonus with one life left
    apply(1'b1, 1'b0, 1'b0);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd2);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    wait_cycles(64);
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd1);
    expect_out(S_GRACE, 8'd1, 1'b1, 1'b1);
    wait_cycles(64);
    expect_out(S_PLAY, 8'd1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1);
    ack_q.push_back(8'd1);
    expect_out(S_GRACE, 8'd1, 1'b1, 1'b1);

    // Start during GRACE, then start with a hit in the same cycle
    apply(1'b1, 1'b0, 1'b0);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b1);
    expect_out(S_PLAY, 8'd3, 1'b0, 1'b1);

    // Bonus inside GRACE, then reset mid-GRACE
    apply(1'b0, 1'b1, 1'b0);
    ack_q.push_back(8'd2);
    expect_out(S_GRACE, 8'd2, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b1);
    expect_out(S_GRACE, 8'd3, 1'b1, 1'b1);
    do_reset(1);
    expect_out(S_IDLE, 8'd3, 1'b0, 1'b1);

    // Drain and final report
    wait_cycles(3);
    while (ack_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL hitack_missing got no pulse required count=%0d", ack_q.pop_front());
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL exp_queue_left got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
